// File: rtl/rgb_matrix_scan.sv
// rgb_matrix_scan: double-buffered 8x8 RGB frame store with row-multiplexed
// LED matrix drive and a blanking gap at the start of every row slot.
module rgb_matrix_scan #(
  parameter int ROW_DIV        = 6250,
  parameter int BLANK_CYCLES   = 16,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       swap_done,
  output logic       frame_start,
  output logic [7:0] led_row,
  output logic [7:0] led_col_r,
  output logic [7:0] led_col_g,
  output logic [7:0] led_col_b
);

  localparam int CW = (ROW_DIV > 2) ? $clog2(ROW_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ROW_DIV - 1);
  localparam logic [CW-1:0] BLK_END = CW'(BLANK_CYCLES);
  localparam logic [7:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic          sel_q, sel_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          fs_q, fs_d;
  logic [7:0]    lrow_q, lrow_d;
  logic [7:0]    lr_q, lr_d;
  logic [7:0]    lg_q, lg_d;
  logic [7:0]    lb_q, lb_d;
  logic [23:0]   fb_q [2][8];

  logic          slot_end;
  logic          swap;
  logic [23:0]   pix;

  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    swap     = slot_end && (row_q == 3'd7) && pend_q;
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    row_d    = slot_end ? row_q + 3'd1 : row_q;
    sel_d    = sel_q ^ swap;
    // a request on the swap edge itself arms the next swap
    pend_d   = swap ? swap_req : (pend_q | swap_req);
    done_d   = swap;
    fs_d     = (cnt_q == '0) && (row_q == 3'd0);
    pix      = fb_q[sel_q][row_q];
    lrow_d   = ROW_OFF;
    lr_d     = COL_OFF;
    lg_d     = COL_OFF;
    lb_d     = COL_OFF;
    if (cnt_q >= BLK_END) begin
      lrow_d = (8'd1 << row_q) ^ ROW_OFF;
      lr_d   = pix[23:16] ^ COL_OFF;
      lg_d   = pix[15:8] ^ COL_OFF;
      lb_d   = pix[7:0] ^ COL_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      row_q  <= '0;
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      fs_q   <= 1'b0;
      lrow_q <= ROW_OFF;
      lr_q   <= COL_OFF;
      lg_q   <= COL_OFF;
      lb_q   <= COL_OFF;
      for (int i = 0; i < 8; i++) begin
        fb_q[0][i] <= '0;
        fb_q[1][i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      sel_q  <= sel_d;
      pend_q <= pend_d;
      done_q <= done_d;
      fs_q   <= fs_d;
      lrow_q <= lrow_d;
      lr_q   <= lr_d;
      lg_q   <= lg_d;
      lb_q   <= lb_d;
      // pre-edge back buffer; on a swap edge that is the new front
      if (wr_en) fb_q[~sel_q][wr_row] <= {wr_r, wr_g, wr_b};
    end
  end

  assign swap_pending = pend_q;
  assign swap_done    = done_q;
  assign frame_start  = fs_q;
  assign led_row      = lrow_q;
  assign led_col_r    = lr_q;
  assign led_col_g    = lg_q;
  assign led_col_b    = lb_q;

endmodule

// File: tb/tb_rgb_matrix_scan.sv
// tb_rgb_matrix_scan: directed scan/swap/reset checks with ROW_DIV=8,
// BLANK_CYCLES=2, row active-high, columns active-low.
module tb_rgb_matrix_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_r = '0;
  logic [7:0] wr_g = '0;
  logic [7:0] wr_b = '0;
  logic       swap_req = 1'b0;
  logic       swap_pending;
  logic       swap_done;
  logic       frame_start;
  logic [7:0] led_row;
  logic [7:0] led_col_r;
  logic [7:0] led_col_g;
  logic [7:0] led_col_b;

  int n_chk = 0;
  int n_fail = 0;
  int pos = -1;
  int done_at = -1;
  logic [7:0] er [8];
  logic [7:0] eg [8];
  logic [7:0] eb [8];

  always #5 clk = ~clk;

  rgb_matrix_scan #(
    .ROW_DIV(8),
    .BLANK_CYCLES(2),
    .ROW_ACTIVE_LOW(0),
    .COL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_row(wr_row),
    .wr_r(wr_r),
    .wr_g(wr_g),
    .wr_b(wr_b),
    .swap_req(swap_req),
    .swap_pending(swap_pending),
    .swap_done(swap_done),
    .frame_start(frame_start),
    .led_row(led_row),
    .led_col_r(led_col_r),
    .led_col_g(led_col_g),
    .led_col_b(led_col_b)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (pos %0d)", tag, got, exp, pos);
    end
  endtask

  task automatic clr_tab();
    for (int i = 0; i < 8; i++) begin
      er[i] = 8'h00;
      eg[i] = 8'h00;
      eb[i] = 8'h00;
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_row"}, led_row, 8'h00);
    check({tag, "_r"}, led_col_r, 8'hFF);
    check({tag, "_g"}, led_col_g, 8'hFF);
    check({tag, "_b"}, led_col_b, 8'hFF);
    check({tag, "_pend"}, 8'(swap_pending), 8'h00);
    check({tag, "_done"}, 8'(swap_done), 8'h00);
    check({tag, "_fs"}, 8'(frame_start), 8'h00);
  endtask

  task automatic scan(input int n);
    int c;
    int r;
    logic drv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pos++;
      c = pos % 8;
      r = (pos / 8) % 8;
      drv = (c >= 2);
      check("row", led_row, drv ? 8'(1 << r) : 8'h00);
      check("col_r", led_col_r, drv ? ~er[r] : 8'hFF);
      check("col_g", led_col_g, drv ? ~eg[r] : 8'hFF);
      check("col_b", led_col_b, drv ? ~eb[r] : 8'hFF);
      check("fstart", 8'(frame_start), 8'(pos % 64 == 0));
      check("sdone", 8'(swap_done), 8'(pos == done_at));
    end
  endtask

  task automatic wr(input logic [2:0] row, input logic [7:0] r,
                    input logic [7:0] g, input logic [7:0] b);
    wr_en = 1'b1;
    wr_row = row;
    wr_r = r;
    wr_g = g;
    wr_b = b;
  endtask

  initial begin
    clr_tab();
    // reset values
    repeat (3) @(negedge clk);
    chk_idle("rst");
    rst = 1'b1;
    pos = -1;

    // write row 3 into back, request swap
    scan(1);
    wr(3'd3, 8'hA5, 8'h0F, 8'h00);
    swap_req = 1'b1;
    done_at = 63;
    scan(1);
    wr_en = 1'b0;
    swap_req = 1'b0;
    check("pend_set", 8'(swap_pending), 8'h01);
    scan(62);
    check("pend_clr", 8'(swap_pending), 8'h00);
    er[3] = 8'hA5;
    eg[3] = 8'h0F;
    eb[3] = 8'h00;
    scan(64);

    // back-buffer isolation
    wr(3'd0, 8'hFF, 8'h00, 8'h00);
    scan(1);
    wr_en = 1'b0;
    scan(191);
    check("iso_pend", 8'(swap_pending), 8'h00);

    // boundary collision
    scan(1);
    swap_req = 1'b1;
    scan(1);
    swap_req = 1'b0;
    check("col_pend", 8'(swap_pending), 8'h01);
    scan(61);
    swap_req = 1'b1;
    wr(3'd7, 8'h01, 8'h00, 8'h00);
    done_at = 383;
    scan(1);
    swap_req = 1'b0;
    wr_en = 1'b0;
    check("col_keep", 8'(swap_pending), 8'h01);
    clr_tab();
    er[0] = 8'hFF;
    er[7] = 8'h01;
    done_at = 447;
    scan(64);
    check("col_pend2", 8'(swap_pending), 8'h00);
    clr_tab();
    er[3] = 8'hA5;
    eg[3] = 8'h0F;
    scan(3);
    swap_req = 1'b1;
    scan(1);
    swap_req = 1'b0;
    check("pre_rst_pend", 8'(swap_pending), 8'h01);
    scan(40);

    // mid-frame reset at row 5, cnt 4
    rst = 1'b0;
    swap_req = 1'b1;
    @(negedge clk);
    chk_idle("mid_rst");
    @(negedge clk);
    chk_idle("mid_rst2");
    rst = 1'b1;
    swap_req = 1'b0;
    pos = -1;
    done_at = -1;
    clr_tab();
    scan(1);
    check("post_pend", 8'(swap_pending), 8'h00);
    swap_req = 1'b1;
    done_at = 63;
    scan(1);
    swap_req = 1'b0;
    scan(62);
    check("post_swap", 8'(swap_pending), 8'h00);
    scan(64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
